// File: rtl/pwm_capture_if.sv
// pwm_capture_if: record output port of pwm_capture.
// One-deep valid/ready register plus timeout and overrun flags.
interface pwm_capture_if #(
  parameter int W = 8
);
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] duty;
  logic [W-1:0] period;
  logic         timeout;
  logic         overrun;

  modport master (
    output out_valid,
    output duty,
    output period,
    output timeout,
    output overrun,
    input  out_ready
  );

  modport slave (
    input  out_valid,
    input  duty,
    input  period,
    input  timeout,
    input  overrun,
    output out_ready
  );
endinterface

// File: rtl/pwm_capture.sv
// pwm_capture: per-period high time and period of a PWM input.
// Optional majority glitch filter: PWM_CAPTURE_GLITCH_FILTER_EN.
module pwm_capture #(
  parameter int W = 8
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          pwm_in,
  pwm_capture_if.master out
);
  localparam logic [W-1:0] CMAX = '1;
  localparam logic [W-1:0] ONE  = W'(1);

  typedef enum logic {
    SYNC,
    MEAS
  } state_t;

  state_t       state;
  state_t       state_nxt;
  logic         sy0;
  logic         sy1;
  logic         s;
  logic         s_d;
  logic         rise;
  logic [W-1:0] cnt;
  logic [W-1:0] cnt_nxt;
  logic [W-1:0] hi;
  logic [W-1:0] hi_nxt;
  logic         emit;
  logic         emit_tmo;
  logic         load;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sy0 <= 1'b0;
      sy1 <= 1'b0;
    end else begin
      sy0 <= pwm_in;
      sy1 <= sy0;
    end
  end

`ifdef PWM_CAPTURE_GLITCH_FILTER_EN
  logic [1:0] hist;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      hist <= 2'b00;
    end else begin
      hist <= {hist[0], sy1};
    end
  end

  // 2-of-3 vote removes single-cycle pulses and dropouts
  assign s = (sy1 & hist[0]) |
             (sy1 & hist[1]) |
             (hist[0] & hist[1]);
`else
  assign s = sy1;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s_d <= 1'b0;
    end else begin
      s_d <= s;
    end
  end

  assign rise = s & ~s_d;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= SYNC;
      cnt   <= '0;
      hi    <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      hi    <= hi_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    hi_nxt    = hi;
    emit      = 1'b0;
    emit_tmo  = 1'b0;
    unique case (state)
      SYNC: begin
        if (rise) begin
          cnt_nxt   = ONE;
          hi_nxt    = ONE;
          state_nxt = MEAS;
        end
      end
      MEAS: begin
        if (rise) begin
          emit    = 1'b1;
          cnt_nxt = ONE;
          hi_nxt  = ONE;
        end else if (cnt == CMAX) begin
          emit      = 1'b1;
          emit_tmo  = 1'b1;
          state_nxt = SYNC;
        end else begin
          cnt_nxt = cnt + ONE;
          hi_nxt  = hi + W'(s);
        end
      end
    endcase
  end

  // a record being accepted this cycle frees the slot for the new one
  assign load = emit & (~out.out_valid | out.out_ready);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      out.out_valid <= 1'b0;
      out.duty      <= '0;
      out.period    <= '0;
      out.timeout   <= 1'b0;
      out.overrun   <= 1'b0;
    end else begin
      out.overrun <= emit & ~load;
      if (load) begin
        out.out_valid <= 1'b1;
        out.duty      <= hi;
        out.period    <= cnt;
        out.timeout   <= emit_tmo;
      end else if (out.out_ready) begin
        out.out_valid <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_pwm_capture.sv
// tb_pwm_capture: directed vectors and corner sequences for pwm_capture.
// Expected records are computed by hand from the drive waveform.
module tb_pwm_capture;
  localparam int W = 8;
`ifdef PWM_CAPTURE_GLITCH_FILTER_EN
  localparam int LAT = 1;
`else
  localparam int LAT = 0;
`endif

  typedef struct {
    int duty;
    int period;
    int tmo;
  } rec_t;

  typedef struct {
    int hi;
    int lo;
    int reps;
    int duty;
    int period;
  } vec_t;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic pwm_in = 1'b0;

  pwm_capture_if #(.W(W)) bus ();

  pwm_capture #(.W(W)) dut (
    .clk    (clk),
    .reset  (reset),
    .pwm_in (pwm_in),
    .out    (bus)
  );

  always #5 clk = ~clk;

  rec_t recq[$];
  int   ovr_cyc = 0;
  int   errors = 0;
  int   checks = 0;

  always @(negedge clk) begin
    if (bus.out_valid && bus.out_ready)
      recq.push_back('{int'(bus.duty), int'(bus.period), int'(bus.timeout)});
    if (bus.overrun)
      ovr_cyc++;
  end

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic lv, input int n);
    pwm_in = lv;
    repeat (n) tick();
  endtask

  task automatic do_reset();
    reset = 1'b1;
    pwm_in = 1'b0;
    bus.out_ready = 1'b1;
    repeat (3) tick();
    reset = 1'b0;
    tick();
  endtask

  task automatic check_rec(input string name, input int idx,
                           input int d, input int p, input int t);
    if (idx < recq.size()) begin
      check({name, "_duty"}, recq[idx].duty, d);
      check({name, "_period"}, recq[idx].period, p);
      check({name, "_timeout"}, recq[idx].tmo, t);
    end else begin
      check({name, "_present"}, 0, 1);
    end
  endtask

  vec_t vt[$];
  int   base;
  int   ob;
  int   bad;

  initial begin
    vt.push_back('{5, 11, 3, 5, 16});
    vt.push_back('{10, 3, 2, 10, 13});
    vt.push_back('{3, 7, 3, 3, 10});
    vt.push_back('{100, 155, 2, 100, 255});
    vt.push_back('{30, 224, 2, 30, 254});
`ifndef PWM_CAPTURE_GLITCH_FILTER_EN
    vt.push_back('{1, 1, 4, 1, 2});
    vt.push_back('{2, 2, 3, 2, 4});
    vt.push_back('{254, 1, 2, 254, 255});
`endif

    // reset held with pwm low
    bus.out_ready = 1'b1;
    bad = 0;
    repeat (20) begin
      @(negedge clk);
      if (bus.out_valid || bus.overrun || bus.timeout ||
          bus.duty != 0 || bus.period != 0)
        bad = 1;
    end
    check("reset_quiet", bad, 0);
    check("reset_valid", int'(bus.out_valid), 0);
    check("reset_duty", int'(bus.duty), 0);
    check("reset_period", int'(bus.period), 0);
    check("reset_timeout", int'(bus.timeout), 0);
    check("reset_overrun", int'(bus.overrun), 0);
    reset = 1'b0;
    tick();

    // table-driven steady waveforms
    foreach (vt[i]) begin
      do_reset();
      base = recq.size();
      ob = ovr_cyc;
      drive(1'b0, 3);
      for (int p = 0; p <= vt[i].reps; p++) begin
        if (p < vt[i].reps) begin
          drive(1'b1, vt[i].hi);
          drive(1'b0, vt[i].lo);
        end else begin
          drive(1'b1, 2);
          drive(1'b0, 4);
        end
      end
      check($sformatf("row%0d_count", i), recq.size() - base, vt[i].reps);
      for (int r = 0; r < vt[i].reps; r++)
        check_rec($sformatf("row%0d_rec%0d", i, r), base + r,
                  vt[i].duty, vt[i].period, 0);
      check($sformatf("row%0d_overrun", i), ovr_cyc - ob, 0);
    end

    // edge-to-record latency and one-cycle valid
    do_reset();
    drive(1'b0, 3);
    drive(1'b1, 5);
    drive(1'b0, 11);
    pwm_in = 1'b1;
    tick();
    tick();
    repeat (LAT) tick();
    @(negedge clk);
    check("lat_early_valid", int'(bus.out_valid), 0);
    tick();
    @(negedge clk);
    check("lat_valid", int'(bus.out_valid), 1);
    check("lat_duty", int'(bus.duty), 5);
    check("lat_period", int'(bus.period), 16);
    tick();
    @(negedge clk);
    check("lat_one_cycle", int'(bus.out_valid), 0);
    drive(1'b1, 1);
    drive(1'b0, 5);

    // backpressure: first record held, next one dropped
    do_reset();
    bus.out_ready = 1'b0;
    base = recq.size();
    ob = ovr_cyc;
    drive(1'b0, 3);
    repeat (3) begin
      drive(1'b1, 5);
      drive(1'b0, 11);
    end
    @(negedge clk);
    check("bp_held_valid", int'(bus.out_valid), 1);
    check("bp_held_duty", int'(bus.duty), 5);
    check("bp_held_period", int'(bus.period), 16);
    check("bp_overrun_cycles", ovr_cyc - ob, 1);
    check("bp_no_accept", recq.size() - base, 0);
    bus.out_ready = 1'b1;
    tick();
    @(negedge clk);
    check("bp_accept_count", recq.size() - base, 1);
    check_rec("bp_release", base, 5, 16, 0);
    check("bp_valid_cleared", int'(bus.out_valid), 0);

    // timeout, then resynchronise
    do_reset();
    base = recq.size();
    drive(1'b0, 3);
    drive(1'b1, 5);
    drive(1'b0, 300);
    check("tmo_count", recq.size() - base, 1);
    check_rec("tmo_rec", base, 5, 255, 1);
    drive(1'b1, 5);
    drive(1'b0, 11);
    check("tmo_resync_count", recq.size() - base, 1);
    drive(1'b1, 2);
    drive(1'b0, 4);
    check("tmo_next_count", recq.size() - base, 2);
    check_rec("tmo_next", base + 1, 5, 16, 0);

    // 1-cycle glitch 3 cycles into the low phase
    do_reset();
    base = recq.size();
    drive(1'b0, 3);
    repeat (4) begin
      drive(1'b1, 5);
      drive(1'b0, 3);
      drive(1'b1, 1);
      drive(1'b0, 7);
    end
    drive(1'b1, 2);
    drive(1'b0, 4);
`ifdef PWM_CAPTURE_GLITCH_FILTER_EN
    check("glitch_count", recq.size() - base, 4);
    for (int r = 0; r < 4; r++)
      check_rec($sformatf("glitch_rec%0d", r), base + r, 5, 16, 0);
`else
    check("glitch_count", recq.size() - base, 8);
    for (int r = 0; r < 8; r++)
      check_rec($sformatf("glitch_rec%0d", r), base + r,
                (r % 2 == 0) ? 5 : 1, 8, 0);
`endif

    // reset mid-measurement with a record held
    do_reset();
    bus.out_ready = 1'b0;
    drive(1'b0, 3);
    repeat (2) begin
      drive(1'b1, 5);
      drive(1'b0, 11);
    end
    drive(1'b1, 5);
    drive(1'b0, 3);
    @(negedge clk);
    check("mid_held_valid", int'(bus.out_valid), 1);
    reset = 1'b1;
    #1;
    check("mid_async_valid", int'(bus.out_valid), 0);
    check("mid_async_period", int'(bus.period), 0);
    tick();
    tick();
    reset = 1'b0;
    bus.out_ready = 1'b1;
    base = recq.size();
    drive(1'b0, 3);
    drive(1'b1, 5);
    drive(1'b0, 11);
    check("mid_first_rise", recq.size() - base, 0);
    drive(1'b1, 2);
    drive(1'b0, 4);
    check("mid_second_rise", recq.size() - base, 1);
    check_rec("mid_rec", base, 5, 16, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
